pc_sp_ctrl: RTL
===============

Name: pc_sp_ctrl

Overview:
- Parametrised successor to the separate program-counter and stack-pointer blocks; merges both into one controller.
- Holds the PC and a descending hardware SP with bounds checking.
- Executes CALL/RET as multi-cycle sequences over a req/ack data-memory port.
- Sits between the instruction decoder (pc_inc/pc_load/call/ret/push/pop strobes) and the data-memory arbiter.

Parameters:
- ADDR_W, 16, width of PC, SP and memory address/data.
- PC_RESET, 0, PC value after reset.
- SP_RESET, 16'h018F, SP after reset; top slot of stack; SP==SP_RESET means empty.
- SP_LIMIT, 16'h0100, lowest valid stack slot; SP==SP_LIMIT-1 means full.
- PC_STEP, 1, PC increment amount.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- pc_inc  in  1  advance PC by PC_STEP.
- pc_load  in  1  load PC from pc_load_addr.
- pc_load_addr  in  ADDR_W  jump target.
- call  in  1  push PC+PC_STEP, then jump to call_target.
- call_target  in  ADDR_W  CALL destination; sampled on accept.
- ret  in  1  pop return address into PC.
- push  in  1  SP adjust only (SP-1); data path is external.
- pop  in  1  SP adjust only (SP+1).
- clr_flags  in  1  clear ovf/unf.
- mem_rdata  in  ADDR_W  read data.
- mem_ack  in  1  memory completes request this cycle.
- mem_req  out  1  memory request, held until ack.
- mem_we  out  1  1=write, 0=read.
- mem_addr  out  ADDR_W  stack slot address.
- mem_wdata  out  ADDR_W  return address to store.
- pc_out  out  ADDR_W  registered PC.
- sp_out  out  ADDR_W  registered SP (points to next free slot).
- busy  out  1  CALL/RET in progress; all strobes ignored.
- ovf  out  1  sticky stack overflow.
- unf  out  1  sticky stack underflow.

Behaviour:
- Reset, asynchronous, active-high: pc_out=PC_RESET, sp_out=SP_RESET, state=IDLE; busy, ovf, unf, mem_req, mem_we = 0; mem_addr, mem_wdata = 0. Reset mid-CALL/RET aborts immediately: mem_req drops the same instant, and no PC/SP update occurs.
- States: IDLE, CALL_WR, RET_RD. busy=1 in CALL_WR and RET_RD.
- IDLE priority, one action per cycle: call > ret > pc_load > pc_inc. push/pop are honoured only when no call/ret is accepted that cycle.
- pc_inc: PC <= PC+PC_STEP, modulo 2^ADDR_W (0xFFFF+1 -> 0x0000).
- pc_load: PC <= pc_load_addr next edge.
- push: if SP==SP_LIMIT-1, set ovf and leave SP unchanged; else SP <= SP-1.
- pop: if SP==SP_RESET, set unf and leave SP unchanged; else SP <= SP+1.
- push & pop in the same cycle: no change, no flag.
- call accepted in IDLE:
  - If full: set ovf, PC unchanged, stay IDLE.
  - Else: latch target and PC+PC_STEP, go to CALL_WR.
- CALL_WR: mem_req=1, mem_we=1, mem_addr=SP, mem_wdata=latched return address. On mem_ack: SP <= SP-1, PC <= latched target, go to IDLE.
- ret accepted in IDLE:
  - If empty: set unf, stay IDLE.
  - Else: go to RET_RD.
- RET_RD: mem_req=1, mem_we=0, mem_addr=SP+1. On mem_ack: PC <= mem_rdata, SP <= SP+1, go to IDLE.
- Latency: CALL/RET with zero-wait ack take 2 cycles (accept edge + ack edge); each wait cycle adds one. New PC is visible on pc_out the cycle after ack.
- mem_* outputs are registered/stable while mem_req=1. mem_ack outside a request is ignored.
- Flags are sticky until clr_flags or reset. A clr_flags coinciding with a new error leaves the flag set (error wins).
- The same strobes are ignored while busy; no queuing.

Decomposition:
- pc_sp_pkg holds:
  - state enum (IDLE, CALL_WR, RET_RD);
  - default constants PC_RESET_D, SP_RESET_D, SP_LIMIT_D;
  - helper functions sp_full(sp) and sp_empty(sp).
- One sub-module, sp_unit: SP register, bounds compare, ovf/unf flags. It takes dec/inc requests and returns full/empty.
- FSM and PC stay in the top level.

Test Plan:
- Reset, then pc_inc x3 -> pc_out=0x0003, sp_out=0x018F, all flags 0. Same cycle pc_load=1 (addr 0x0040) and pc_inc=1 -> pc_out=0x0040.
- PC=0x0010, call target 0x0200, ack after 2 wait cycles -> write addr 0x018F with data 0x0011; busy for 3 cycles; then pc_out=0x0200, sp_out=0x018E.
- Continuing from the previous scenario, ret with ack mem_rdata=0x0011 -> read addr 0x018F, pc_out=0x0011, sp_out=0x018F. A pc_inc pulsed while busy is ignored.
- 0x90 pushes from reset -> sp_out=0x00FF. Next push and next call -> ovf=1, SP and PC unchanged, mem_req never asserted. clr_flags -> ovf=0.
- From reset, pop -> unf=1. ret -> unf stays 1, mem_req=0. Simultaneous push+pop -> sp_out unchanged.
- Assert reset while in CALL_WR before ack -> mem_req=0 and busy=0 immediately; after release pc_out=PC_RESET, sp_out=0x018F. PC=0xFFFF with pc_inc -> 0x0000.

Source files
------------

// File: rtl/pc_sp_ctrl_pkg.sv
// Shared types, defaults and stack-bound helpers for the
// combined program-counter / stack-pointer controller.
package pc_sp_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CALL_WR,
    RET_RD
  } state_t;

  localparam logic [15:0] PC_RESET_D = 16'h0000;
  localparam logic [15:0] SP_RESET_D = 16'h018F;
  localparam logic [15:0] SP_LIMIT_D = 16'h0100;

  // Full means the slot below the lowest valid one is next.
  function automatic logic sp_full(
    input logic [31:0] sp,
    input logic [31:0] limit = 32'(SP_LIMIT_D)
  );
    return sp == (limit - 32'd1);
  endfunction

  function automatic logic sp_empty(
    input logic [31:0] sp,
    input logic [31:0] top = 32'(SP_RESET_D)
  );
    return sp == top;
  endfunction

endpackage

// File: rtl/pc_sp_ctrl_if.sv
// Data-memory request/acknowledge port between the
// controller (master) and the memory arbiter (slave).
interface pc_sp_ctrl_if #(
  parameter int ADDR_W = 16
);
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [ADDR_W-1:0] mem_wdata;
  logic [ADDR_W-1:0] mem_rdata;
  logic              mem_ack;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_rdata, mem_ack
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_rdata, mem_ack
  );
endinterface

// File: rtl/pc_sp_ctrl_sp_unit.sv
// Descending stack pointer with bounds checks and sticky
// overflow/underflow flags.
module sp_unit
  import pc_sp_pkg::*;
#(
  parameter int              ADDR_W   = 16,
  parameter logic [ADDR_W-1:0] SP_RESET = ADDR_W'(SP_RESET_D),
  parameter logic [ADDR_W-1:0] SP_LIMIT = ADDR_W'(SP_LIMIT_D)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              dec,
  input  logic              inc,
  input  logic              clr_flags,
  output logic [ADDR_W-1:0] sp,
  output logic              full,
  output logic              empty,
  output logic              ovf,
  output logic              unf
);

  localparam logic [ADDR_W-1:0] ONE = ADDR_W'(1);

  logic dec_only;
  logic inc_only;
  logic set_ovf;
  logic set_unf;

  assign full     = sp_full(32'(sp), 32'(SP_LIMIT));
  assign empty    = sp_empty(32'(sp), 32'(SP_RESET));
  assign dec_only = dec & ~inc;
  assign inc_only = inc & ~dec;
  assign set_ovf  = dec_only & full;
  assign set_unf  = inc_only & empty;

  // A new error in the same cycle as a clear keeps the flag set.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sp  <= SP_RESET;
      ovf <= 1'b0;
      unf <= 1'b0;
    end else begin
      if (dec_only && !full) begin
        sp <= sp - ONE;
      end else if (inc_only && !empty) begin
        sp <= sp + ONE;
      end
      ovf <= set_ovf | (ovf & ~clr_flags);
      unf <= set_unf | (unf & ~clr_flags);
    end
  end

endmodule

// File: rtl/pc_sp_ctrl.sv
// Program counter plus hardware stack controller; runs
// CALL/RET as request/acknowledge sequences on the data port.
module pc_sp_ctrl
  import pc_sp_pkg::*;
#(
  parameter int                ADDR_W   = 16,
  parameter logic [ADDR_W-1:0] PC_RESET = ADDR_W'(PC_RESET_D),
  parameter logic [ADDR_W-1:0] SP_RESET = ADDR_W'(SP_RESET_D),
  parameter logic [ADDR_W-1:0] SP_LIMIT = ADDR_W'(SP_LIMIT_D),
  parameter int                PC_STEP  = 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               pc_inc,
  input  logic               pc_load,
  input  logic [ADDR_W-1:0]  pc_load_addr,
  input  logic               call,
  input  logic [ADDR_W-1:0]  call_target,
  input  logic               ret,
  input  logic               push,
  input  logic               pop,
  input  logic               clr_flags,
  pc_sp_ctrl_if.master       mem,
  output logic [ADDR_W-1:0]  pc_out,
  output logic [ADDR_W-1:0]  sp_out,
  output logic               busy,
  output logic               ovf,
  output logic               unf
);

  localparam logic [ADDR_W-1:0] STEP = ADDR_W'(PC_STEP);
  localparam logic [ADDR_W-1:0] ONE  = ADDR_W'(1);

  state_t            state;
  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] tgt;
  logic [ADDR_W-1:0] sp;
  logic              full;
  logic              empty;
  logic              idle;
  logic              act_call;
  logic              act_ret;
  logic              act_ld;
  logic              act_inc;
  logic              sp_dec;
  logic              sp_inc;

  assign idle     = (state == IDLE);
  assign act_call = idle & call;
  assign act_ret  = idle & ~call & ret;
  assign act_ld   = idle & ~call & ~ret & pc_load;
  assign act_inc  = idle & ~call & ~ret & ~pc_load & pc_inc;

  // A refused call/ret is routed to the SP unit to raise its flag.
  always_comb begin
    sp_dec = 1'b0;
    sp_inc = 1'b0;
    if (idle) begin
      if (call) begin
        sp_dec = full;
      end else if (ret) begin
        sp_inc = empty;
      end else begin
        sp_dec = push;
        sp_inc = pop;
      end
    end else if (state == CALL_WR) begin
      sp_dec = mem.mem_ack;
    end else begin
      sp_inc = mem.mem_ack;
    end
  end

  sp_unit #(
    .ADDR_W   (ADDR_W),
    .SP_RESET (SP_RESET),
    .SP_LIMIT (SP_LIMIT)
  ) u_sp (
    .clk       (clk),
    .reset     (reset),
    .dec       (sp_dec),
    .inc       (sp_inc),
    .clr_flags (clr_flags & idle),
    .sp        (sp),
    .full      (full),
    .empty     (empty),
    .ovf       (ovf),
    .unf       (unf)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      pc            <= PC_RESET;
      tgt           <= '0;
      busy          <= 1'b0;
      mem.mem_req   <= 1'b0;
      mem.mem_we    <= 1'b0;
      mem.mem_addr  <= '0;
      mem.mem_wdata <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          unique case (1'b1)
            act_call: begin
              if (!full) begin
                state         <= CALL_WR;
                busy          <= 1'b1;
                tgt           <= call_target;
                mem.mem_req   <= 1'b1;
                mem.mem_we    <= 1'b1;
                mem.mem_addr  <= sp;
                mem.mem_wdata <= pc + STEP;
              end
            end
            act_ret: begin
              if (!empty) begin
                state        <= RET_RD;
                busy         <= 1'b1;
                mem.mem_req  <= 1'b1;
                mem.mem_we   <= 1'b0;
                mem.mem_addr <= sp + ONE;
              end
            end
            act_ld:  pc <= pc_load_addr;
            act_inc: pc <= pc + STEP;
            default: ;
          endcase
        end
        CALL_WR, RET_RD: begin
          if (mem.mem_ack) begin
            pc            <= (state == CALL_WR) ? tgt : mem.mem_rdata;
            state         <= IDLE;
            busy          <= 1'b0;
            mem.mem_req   <= 1'b0;
            mem.mem_we    <= 1'b0;
            mem.mem_addr  <= '0;
            mem.mem_wdata <= '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign pc_out = pc;
  assign sp_out = sp;

endmodule
